switches_debounce_wb8: RTL and testbench
========================================

Name: switches_debounce_wb8

Overview:
- Parametrised successor to the 2-bit switch reader: 8-bit Wishbone slave sampling up to 8 mechanical switches/buttons.
- Each channel has a 2-flop synchroniser, a counter-based debouncer, and edge detection into sticky event flags.
- Sits on the SPU32 peripheral bus alongside the LED and UART slaves; software polls the state or event registers, or optionally takes an interrupt.

Parameters:
- NUM_SWITCHES, 2, channel count; legal 1..8; unused data bits read 0.
- DEBOUNCE_CYCLES, 16, consecutive stable clocks required to accept a new level; legal >= 1.
- ACTIVE_LOW, 0, when 1 each input is inverted after synchronisation, so a pressed switch reads 1.

Ports:
- I_wb_clk  in  1  system clock; sole clock of the block.
- I_reset  in  1  asynchronous, active-high reset.
- I_wb_stb  in  1  Wishbone strobe/cycle.
- I_wb_we  in  1  write enable.
- I_wb_adr  in  2  register select.
- I_wb_dat  in  8  write data.
- O_wb_ack  out  1  acknowledge.
- O_wb_dat  out  8  read data, registered.
- I_switches  in  NUM_SWITCHES  raw asynchronous switch inputs.
- O_irq  out  1  level interrupt request.

Behaviour:
- Reset (async, active-high):
  - Sync flops, debounced state, counters, EVENT, EDGE_CFG, IRQ_MASK, O_wb_dat, O_wb_ack and O_irq all clear to 0.
  - Reset mid-debounce discards partial counts.
  - The first post-reset debounced level is 0 after ACTIVE_LOW inversion, so a switch held at reset produces a rising event DEBOUNCE_CYCLES+2 clocks after release of reset.
- Synchroniser: 2 flops per channel; the raw-to-sync latency is 2 clocks.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync != stable, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync != stable, stable takes sync and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks never changes stable.
  - With DEBOUNCE_CYCLES=1, stable follows sync with 1 clock of delay.
- Edge detect, per channel:
  - A stable transition 0->1 with EDGE_CFG[i]=0 sets EVENT[i] for one clock.
  - A stable transition 1->0 with EDGE_CFG[i]=1 sets EVENT[i] for one clock.
  - EVENT bits are sticky.
- Register map (byte addresses):
  - 0 STATE (RO): debounced levels, zero-extended.
  - 1 EVENT (R/W1C): writing 1 clears a bit; writing 0 has no effect.
  - 2 EDGE_CFG (RW).
  - 3 IRQ_MASK (RW).
  - Writes to STATE are ignored.
  - Bits at or above NUM_SWITCHES are not stored and read 0.
- Handshake:
  - Accept when I_wb_stb && !O_wb_ack. O_wb_ack asserts the next clock for exactly one cycle, giving 1 wait state per access.
  - For a held strobe, ack alternates, so each ack completes one access.
  - On a read accept, O_wb_dat loads the selected register; it holds its value otherwise.
  - On a write accept, the register updates at that same clock edge.
- Simultaneous events:
  - A set of EVENT[i] and a W1C clear of EVENT[i] in the same clock: set wins and the bit stays 1.
  - A read of EVENT in the clock an edge arrives returns the pre-edge value.
  - An EDGE_CFG write takes effect for transitions from the next clock.
- O_irq: registered; O_irq = |(EVENT & IRQ_MASK), one clock after the EVENT update.

Optional Feature:
- SWITCHES_IRQ_EN defined: IRQ_MASK is implemented and O_irq behaves as in Behaviour.
- Not defined:
  - IRQ_MASK storage is omitted; address 3 reads 0 and writes are ignored.
  - O_irq is tied to 0.
  - All other behaviour is unchanged.

Decomposition:
- Shared package/header holds:
  - Register address constants: SW_REG_STATE=0, SW_REG_EVENT=1, SW_REG_EDGE=2, SW_REG_MASK=3.
  - The maximum channel constant, 8.
- One natural sub-module, switch_debounce: a single channel containing the synchroniser, counter and stable flop. It has parameters DEBOUNCE_CYCLES and ACTIVE_LOW and outputs stable plus rise/fall pulses. It is instantiated NUM_SWITCHES times via generate.
- The top level holds the Wishbone decode, EVENT/EDGE_CFG/IRQ_MASK and the IRQ logic.

Test Plan:
- Reset with inputs=2'b00, then read adr 0: ack one cycle after stb, O_wb_dat=0x00; O_irq=0.
- Glitch: set I_switches[0]=1 for 10 clocks then back to 0 (DEBOUNCE_CYCLES=16) -> STATE stays 0x00, EVENT stays 0x00.
- Press and hold channel 1 for 40 clocks -> STATE=0x02 exactly 2+16 clocks after the input change; EVENT=0x02; writing 0x02 to adr 1 clears EVENT to 0x00.
- EDGE_CFG=0x01 and IRQ_MASK=0x01:
  - Press channel 0 -> no event.
  - Release channel 0 -> EVENT=0x01 and O_irq=1 one clock later.
  - W1C of EVENT -> O_irq=0.
- Edge and W1C of the same bit in the same clock -> EVENT bit reads 1 afterwards.
- Assert I_reset mid-count (counter at 8), then release with the input held -> no stale event; the full DEBOUNCE_CYCLES count is required again. Build without SWITCHES_IRQ_EN -> adr 3 reads 0x00 and O_irq stays 0.

Source files
------------

// File: rtl/switches_debounce_wb8_pkg.sv
// Shared definitions for the switches_debounce_wb8 Wishbone switch reader:
// register addresses and the maximum channel count.
package switches_debounce_wb8_pkg;

    // Widest channel count the 8-bit data bus can carry.
    localparam int SW_MAX_CHANNELS = 8;

    // Register select values on I_wb_adr.
    typedef enum logic [1:0] {
        SW_REG_STATE = 2'd0,  // debounced levels, read-only
        SW_REG_EVENT = 2'd1,  // sticky edge flags, write-1-to-clear
        SW_REG_EDGE  = 2'd2,  // per-channel edge select: 0 rising, 1 falling
        SW_REG_MASK  = 2'd3   // interrupt mask
    } sw_reg_e;

endpackage

// File: rtl/switches_debounce_wb8_switch_debounce.sv
// One switch channel: 2-flop synchroniser, optional inversion, counter-based
// debouncer and a stable-level flop. rise/fall are single-cycle strobes that
// coincide with the clock edge at which the stable level changes.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             level;

    // Next-state: shift the synchroniser, count disagreement, accept a new level.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sync_d   = {sync_q[0], raw};
        level    = sync_q[1] ^ ACTIVE_LOW;
        cnt_d    = '0;
        stable_d = stable_q;
        if (level != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
    end

    // Channel state registers; reset discards any partial count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switches_debounce_wb8.sv
// 8-bit Wishbone slave reading up to 8 debounced switches with sticky edge
// events. Define SWITCHES_IRQ_EN to implement IRQ_MASK and drive O_irq;
// otherwise address 3 reads 0, its writes are dropped and O_irq is held low.
module switches_debounce_wb8
    import switches_debounce_wb8_pkg::*;
#(
    parameter int NUM_SWITCHES    = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                    I_wb_clk,
    input  logic                    I_reset,
    input  logic                    I_wb_stb,
    input  logic                    I_wb_we,
    input  logic [1:0]              I_wb_adr,
    input  logic [7:0]              I_wb_dat,
    output logic                    O_wb_ack,
    output logic [7:0]              O_wb_dat,
    input  logic [NUM_SWITCHES-1:0] I_switches,
    output logic                    O_irq
);

    localparam int N = NUM_SWITCHES;

    logic [N-1:0] stable, rise, fall, hit, wdat;
    logic [N-1:0] event_q, event_d, edge_q, edge_d;
    logic         ack_q, ack_d;
    logic [7:0]   dat_q, dat_d;
    logic [SW_MAX_CHANNELS-1:0] rd_val;
    logic         accept, wr, rd;
    logic         unused_dat;

`ifdef SWITCHES_IRQ_EN
    logic [N-1:0] mask_q, mask_d;
    logic         irq_q, irq_d;
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk    (I_wb_clk),
            .rst    (I_reset),
            .raw    (I_switches[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Upper write-data bits have no storage when fewer than 8 channels exist.
    assign unused_dat = ^I_wb_dat;

    // Bus decode, register next-state and read mux.
    always_comb begin
        accept = I_wb_stb && !ack_q;
        wr     = accept && I_wb_we;
        rd     = accept && !I_wb_we;
        wdat   = I_wb_dat[N-1:0];
        // Edge selection uses the pre-write EDGE_CFG, so a write applies from the next clock.
        hit    = (rise & ~edge_q) | (fall & edge_q);

        edge_d  = edge_q;
        event_d = event_q;
        if (wr && sw_reg_e'(I_wb_adr) == SW_REG_EDGE)  edge_d  = wdat;
        if (wr && sw_reg_e'(I_wb_adr) == SW_REG_EVENT) event_d = event_q & ~wdat;
        // A new edge wins over a simultaneous clear.
        event_d = event_d | hit;

`ifdef SWITCHES_IRQ_EN
        mask_d = mask_q;
        if (wr && sw_reg_e'(I_wb_adr) == SW_REG_MASK) mask_d = wdat;
        irq_d  = |(event_q & mask_q);
`endif

        rd_val = '0;
        case (sw_reg_e'(I_wb_adr))
            SW_REG_STATE: rd_val[N-1:0] = stable;
            SW_REG_EVENT: rd_val[N-1:0] = event_q;
            SW_REG_EDGE:  rd_val[N-1:0] = edge_q;
`ifdef SWITCHES_IRQ_EN
            SW_REG_MASK:  rd_val[N-1:0] = mask_q;
`endif
            default:      rd_val = '0;
        endcase

        ack_d = accept;
        dat_d = rd ? rd_val : dat_q;
    end

    // Bus and event registers.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            event_q <= '0;
            edge_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            event_q <= event_d;
            edge_q  <= edge_d;
        end
    end

`ifdef SWITCHES_IRQ_EN
    // Interrupt mask and registered level interrupt.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign O_irq = irq_q;
`else
    assign O_irq = 1'b0;
`endif

    assign O_wb_ack = ack_q;
    assign O_wb_dat = dat_q;

endmodule

// File: tb/tb_switches_debounce_wb8.sv
// Directed bench for switches_debounce_wb8 (NUM_SWITCHES=2, DEBOUNCE_CYCLES=16).
// Read expectations go into a scoreboard queue when the access is issued and
// are compared when the acknowledge returns. Follows SWITCHES_IRQ_EN.
module tb_switches_debounce_wb8;

`ifdef SWITCHES_IRQ_EN
    localparam logic IRQ_EXP  = 1'b1;
    localparam logic [7:0] MASK_RB = 8'h03;
`else
    localparam logic IRQ_EXP  = 1'b0;
    localparam logic [7:0] MASK_RB = 8'h00;
`endif

    logic       I_wb_clk = 1'b0;
    logic       I_reset  = 1'b1;
    logic       I_wb_stb = 1'b0;
    logic       I_wb_we  = 1'b0;
    logic [1:0] I_wb_adr = 2'd0;
    logic [7:0] I_wb_dat = 8'h00;
    logic [1:0] I_switches = 2'b00;
    logic       O_wb_ack;
    logic [7:0] O_wb_dat;
    logic       O_irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    switches_debounce_wb8 #(
        .NUM_SWITCHES    (2),
        .DEBOUNCE_CYCLES (16),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .I_wb_clk   (I_wb_clk),
        .I_reset    (I_reset),
        .I_wb_stb   (I_wb_stb),
        .I_wb_we    (I_wb_we),
        .I_wb_adr   (I_wb_adr),
        .I_wb_dat   (I_wb_dat),
        .O_wb_ack   (O_wb_ack),
        .O_wb_dat   (O_wb_dat),
        .I_switches (I_switches),
        .O_irq      (O_irq)
    );

    always #5 I_wb_clk = ~I_wb_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge I_wb_clk);
        #1;
    endtask

    // One access: accepted at the next edge, ack seen after it, then one idle clock.
    task automatic xfer(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                        input logic [7:0] exp, input string tag);
        int cyc;
        logic [7:0] e;
        string t;
        if (!we) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        I_wb_stb = 1'b1;
        I_wb_we  = we;
        I_wb_adr = adr;
        I_wb_dat = wdat;
        cyc = 0;
        do begin
            @(posedge I_wb_clk);
            #1;
            cyc++;
        end while (!O_wb_ack && cyc < 8);
        I_wb_stb = 1'b0;
        I_wb_we  = 1'b0;
        check({tag, "_ack_latency"}, 8'(cyc), 8'd1);
        if (!we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, O_wb_dat, e);
        end
        tick(1);
        check({tag, "_ack_single"}, {7'b0, O_wb_ack}, 8'h00);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [7:0] exp, input string tag);
        xfer(1'b0, adr, 8'h00, exp, tag);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] wdat, input string tag);
        xfer(1'b1, adr, wdat, 8'h00, tag);
    endtask

    initial begin
        // Reset state.
        tick(3);
        check("rst_ack", {7'b0, O_wb_ack}, 8'h00);
        check("rst_dat", O_wb_dat, 8'h00);
        check("rst_irq", {7'b0, O_irq}, 8'h00);
        I_reset = 1'b0;
        tick(2);
        rd(2'd0, 8'h00, "reset_state");
        rd(2'd1, 8'h00, "reset_event");
        rd(2'd2, 8'h00, "reset_edge");

        // 10-clock glitch on channel 0 never reaches the stable level.
        I_switches = 2'b01;
        tick(10);
        I_switches = 2'b00;
        tick(30);
        rd(2'd0, 8'h00, "glitch_state");
        rd(2'd1, 8'h00, "glitch_event");

        // Press channel 1: stable rises at the 18th edge after the change.
        I_switches = 2'b10;
        tick(17);
        rd(2'd0, 8'h00, "press_state_edge18_pre");
        tick(20);
        rd(2'd0, 8'h02, "press_state");
        rd(2'd1, 8'h02, "press_event");
        wr(2'd1, 8'h00, "w1c_zero");
        rd(2'd1, 8'h02, "w1c_zero_keeps");
        wr(2'd0, 8'hFF, "state_write");
        rd(2'd0, 8'h02, "state_write_ignored");
        wr(2'd1, 8'h02, "w1c_ch1");
        rd(2'd1, 8'h00, "w1c_ch1_cleared");

        // Release channel 1: stable falls by edge 18, no event with rising select.
        I_switches = 2'b00;
        tick(18);
        rd(2'd0, 8'h00, "release_state");
        rd(2'd1, 8'h00, "release_no_event");

        // Edge select and mask; bits above channel count are not stored.
        wr(2'd2, 8'hFF, "edge_all");
        rd(2'd2, 8'h03, "edge_readback");
        wr(2'd2, 8'h01, "edge_ch0_fall");
        rd(2'd2, 8'h01, "edge_ch0_readback");
        wr(2'd3, 8'hFF, "mask_all");
        rd(2'd3, MASK_RB, "mask_readback");
        wr(2'd3, 8'h01, "mask_ch0");

        // Channel 0 with falling select: press is silent, release raises EVENT then IRQ.
        I_switches = 2'b01;
        tick(30);
        rd(2'd1, 8'h00, "fall_cfg_press_no_event");
        rd(2'd0, 8'h01, "fall_cfg_press_state");
        check("irq_idle", {7'b0, O_irq}, 8'h00);
        I_switches = 2'b00;
        tick(18);
        check("irq_same_edge_low", {7'b0, O_irq}, 8'h00);
        tick(1);
        check("irq_after_event", {7'b0, O_irq}, {7'b0, IRQ_EXP});
        rd(2'd1, 8'h01, "fall_event");
        wr(2'd1, 8'h01, "fall_w1c");
        check("irq_cleared", {7'b0, O_irq}, 8'h00);
        rd(2'd1, 8'h00, "fall_event_cleared");

        // Falling edge and W1C of the same bit at the same clock: edge wins.
        I_switches = 2'b01;
        tick(30);
        I_switches = 2'b00;
        tick(17);
        wr(2'd1, 8'h01, "collide_w1c");
        rd(2'd1, 8'h01, "collide_event_kept");
        check("collide_irq", {7'b0, O_irq}, {7'b0, IRQ_EXP});
        wr(2'd1, 8'h01, "collide_clear");
        rd(2'd1, 8'h00, "collide_cleared");

        // Read of EVENT in the clock the edge lands returns the pre-edge value.
        I_switches = 2'b10;
        tick(17);
        rd(2'd1, 8'h00, "edge_clock_read_pre");
        rd(2'd1, 8'h02, "edge_clock_read_post");
        check("irq_masked_ch1", {7'b0, O_irq}, 8'h00);
        wr(2'd1, 8'h02, "edge_clock_clear");

        // Reset mid-count with the input held: full count needed again.
        I_switches = 2'b01;
        tick(10);
        I_reset = 1'b1;
        tick(3);
        check("midrst_ack", {7'b0, O_wb_ack}, 8'h00);
        check("midrst_dat", O_wb_dat, 8'h00);
        check("midrst_irq", {7'b0, O_irq}, 8'h00);
        I_reset = 1'b0;
        tick(17);
        rd(2'd0, 8'h00, "midrst_state_edge18_pre");
        rd(2'd1, 8'h01, "midrst_event");
        rd(2'd0, 8'h01, "midrst_state");
        rd(2'd2, 8'h00, "midrst_edge_cleared");
        rd(2'd3, 8'h00, "midrst_mask_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
